// File: rtl/mult_div_ctrl_if.sv
// Handshake and result bus between the control unit and the HI/LO multiply/divide sequencer.
interface mult_div_ctrl_if #(parameter int WIDTH = 32);
  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start_mult, start_div, op_a, op_b,
                  input  busy, done, div_zero, hi, lo);
  modport slave  (input  start_mult, start_div, op_a, op_b,
                  output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mult_div_ctrl.sv
// Signed radix-2 multiply / restoring divide sequencer owning HI/LO, one iteration per clock.
// Optional MULT_DIV_ZERO_SHORTCUT_EN: multiplies with a zero operand skip straight to FINISH.
module mult_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_ctrl_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, MULT, DIV, FINISH, DZERO} state_t;
  state_t state, stateNext;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   upper, lower, operand, hiR, loR;
  logic               isDiv, negRes, negRem, doneR;
  logic               busyC, divZeroC;
  logic [WIDTH-1:0]   magA, magB;
  logic               lastIter, multZero;

  assign magA     = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
  assign magB     = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;
  assign lastIter = (cnt == CW'(WIDTH-1));

`ifdef MULT_DIV_ZERO_SHORTCUT_EN
  assign multZero = (bus.op_a == '0) || (bus.op_b == '0);
`else
  assign multZero = 1'b0;
`endif

  // Shift-add step: {upper,lower} holds partial product over the remaining multiplier bits.
  logic [WIDTH:0]   mulSum;
  assign mulSum = {1'b0, upper} + (lower[0] ? {1'b0, operand} : '0);

  // Restoring step: remainder in upper, dividend shifting out of lower, quotient shifting in.
  logic [WIDTH:0]   shifted;
  logic             geq;
  logic [WIDTH-1:0] diffLow;
  assign shifted = {upper, lower[WIDTH-1]};
  assign geq     = (shifted >= {1'b0, operand});
  assign diffLow = shifted[WIDTH-1:0] - operand;

  logic [2*WIDTH-1:0] prodS;
  logic [WIDTH-1:0]   quo, remS;
  assign prodS = negRes ? -{upper, lower} : {upper, lower};
  assign quo   = negRes ? -lower : lower;
  assign remS  = negRem ? -upper : upper;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    busyC     = 1'b1;
    divZeroC  = 1'b0;
    case (state)
      IDLE: begin
        busyC = 1'b0;
        if (bus.start_mult)     stateNext = multZero ? FINISH : MULT;
        else if (bus.start_div) stateNext = (bus.op_b == '0) ? DZERO : DIV;
      end
      MULT, DIV: if (lastIter) stateNext = FINISH;
      FINISH:    stateNext = IDLE;
      DZERO: begin
        divZeroC  = 1'b1;
        stateNext = IDLE;
      end
      default:   stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0; upper <= '0; lower <= '0; operand <= '0;
      hiR <= '0; loR <= '0; isDiv <= 1'b0; negRes <= 1'b0; negRem <= 1'b0;
      doneR <= 1'b0;
    end else begin
      doneR <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_mult) begin
            isDiv   <= 1'b0;
            upper   <= '0;
            lower   <= multZero ? '0 : magB;
            operand <= magA;
            negRes  <= multZero ? 1'b0 : (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
            cnt     <= '0;
          end else if (bus.start_div && bus.op_b != '0) begin
            isDiv   <= 1'b1;
            upper   <= '0;
            lower   <= magA;
            operand <= magB;
            negRes  <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
            negRem  <= bus.op_a[WIDTH-1];
            cnt     <= '0;
          end
        end
        MULT: begin
          upper <= mulSum[WIDTH:1];
          lower <= {mulSum[0], lower[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
        end
        DIV: begin
          upper <= geq ? diffLow : shifted[WIDTH-1:0];
          lower <= {lower[WIDTH-2:0], geq};
          cnt   <= cnt + 1'b1;
        end
        FINISH: begin
          doneR <= 1'b1;
          if (isDiv) begin
            hiR <= remS;
            loR <= quo;
          end else begin
            {hiR, loR} <= prodS;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busyC;
  assign bus.div_zero = divZeroC;
  assign bus.done     = doneR;
  assign bus.hi       = hiR;
  assign bus.lo       = loR;
endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed table-driven bench for mult_div_ctrl plus hand sequences for multi-cycle corners.
module tb_mult_div_ctrl;
  localparam int W   = 32;
  localparam int LAT = W + 1;
`ifdef MULT_DIV_ZERO_SHORTCUT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = LAT;
`endif

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  mult_div_ctrl_if #(.WIDTH(W)) bus ();
  mult_div_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset(rstN), .bus(bus));

  typedef struct {
    logic        isDiv;
    logic        both;
    logic [31:0] a, b, expHi, expLo;
  } vec_t;

  vec_t vecs[15];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic startOp(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start_mult = m; bus.start_div = d; bus.op_a = a; bus.op_b = b;
    @(posedge clk); #1;
    bus.start_mult = 1'b0; bus.start_div = 1'b0;
  endtask

  // Counts edges after the start edge until done is seen; bounded.
  task automatic waitDone(output int n, output logic busyOk, output logic dzSeen);
    n = 0; busyOk = 1'b1; dzSeen = 1'b0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (bus.div_zero) dzSeen = 1'b1;
      if (bus.done) break;
      if (!bus.busy) busyOk = 1'b0;
    end
  endtask

  initial begin
    int n, doneSeen, lat;
    logic bOk, dz;

    vecs[0]  = '{1'b0, 1'b0, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{1'b0, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    vecs[2]  = '{1'b1, 1'b0, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000};
    vecs[4]  = '{1'b0, 1'b1, 32'h3,        32'h4,        32'h0,        32'hC};
    vecs[5]  = '{1'b1, 1'b0, 32'd100,      32'd7,        32'h2,        32'hE};
    vecs[6]  = '{1'b1, 1'b0, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2};
    vecs[7]  = '{1'b1, 1'b0, 32'd100,      32'hFFFFFFF9, 32'h2,        32'hFFFFFFF2};
    vecs[8]  = '{1'b1, 1'b0, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hE};
    vecs[9]  = '{1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h1};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        32'h5,        32'h0,        32'h0};
    vecs[12] = '{1'b0, 1'b0, 32'h80000000, 32'h1,        32'hFFFFFFFF, 32'h80000000};
    vecs[13] = '{1'b1, 1'b0, 32'd3,        32'd7,        32'h3,        32'h0};
    vecs[14] = '{1'b1, 1'b0, 32'h451,      32'h20,       32'h11,       32'h22};

    rstN = 1'b0;
    bus.start_mult = 1'b0; bus.start_div = 1'b0; bus.op_a = '0; bus.op_b = '0;
    #23;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dz",   bus.div_zero, 0);
    check("rst_hi",   bus.hi, 0);
    check("rst_lo",   bus.lo, 0);
    @(negedge clk); rstN = 1'b1;

    for (int i = 0; i < 15; i++) begin
      startOp(!vecs[i].isDiv || vecs[i].both, vecs[i].isDiv || vecs[i].both, vecs[i].a, vecs[i].b);
      waitDone(n, bOk, dz);
      lat = (!vecs[i].isDiv && (vecs[i].a == 0 || vecs[i].b == 0)) ? ZLAT : LAT;
      check($sformatf("v%0d_lat", i),     n, lat);
      check($sformatf("v%0d_hi", i),      bus.hi, vecs[i].expHi);
      check($sformatf("v%0d_lo", i),      bus.lo, vecs[i].expLo);
      check($sformatf("v%0d_busy", i),    bOk, 1);
      check($sformatf("v%0d_busyEnd", i), bus.busy, 0);
    end

    // Divide by zero leaves the preloaded HI/LO (0x11/0x22) intact.
    @(negedge clk);
    bus.start_div = 1'b1; bus.op_a = 32'd5; bus.op_b = 32'd0;
    @(posedge clk); #1;
    bus.start_div = 1'b0;
    check("dz_pulse", bus.div_zero, 1);
    check("dz_busy",  bus.busy, 1);
    check("dz_done",  bus.done, 0);
    @(posedge clk); #1;
    check("dz_pulseEnd", bus.div_zero, 0);
    check("dz_busyEnd",  bus.busy, 0);
    doneSeen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) doneSeen++;
    end
    check("dz_noDone", doneSeen, 0);
    check("dz_hi", bus.hi, 32'h11);
    check("dz_lo", bus.lo, 32'h22);

    // A divide request while busy is dropped, even one that would fault.
    startOp(1'b1, 1'b0, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.start_div = 1'b1; bus.op_a = 32'd9; bus.op_b = 32'd0;
    @(negedge clk);
    bus.start_div = 1'b0;
    waitDone(n, bOk, dz);
    check("ign_lat", n, LAT - 10);
    check("ign_dz",  dz, 0);
    check("ign_hi",  bus.hi, 0);
    check("ign_lo",  bus.lo, 32'hC);

    // Back-to-back: start raised during the done cycle is accepted.
    startOp(1'b1, 1'b0, 32'd2, 32'd5);
    waitDone(n, bOk, dz);
    check("b2b_lo1", bus.lo, 32'hA);
    bus.start_mult = 1'b1; bus.op_a = 32'd6; bus.op_b = 32'd7;
    @(posedge clk); #1;
    bus.start_mult = 1'b0;
    check("b2b_busy", bus.busy, 1);
    waitDone(n, bOk, dz);
    check("b2b_lat", n, LAT);
    check("b2b_lo2", bus.lo, 32'h2A);

    // Asynchronous reset partway through a multiply.
    startOp(1'b1, 1'b0, 32'h12345, 32'h6789);
    repeat (10) @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_hi",   bus.hi, 0);
    check("arst_lo",   bus.lo, 0);
    check("arst_done", bus.done, 0);
    @(negedge clk); rstN = 1'b1;
    startOp(1'b1, 1'b0, 32'd2, 32'd3);
    waitDone(n, bOk, dz);
    check("arst_lat", n, LAT);
    check("arst_res", bus.lo, 32'h6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
